// File: rtl/fill_pkg.sv
// Shared state encoding and timing constants for the instruction-fill loader.
package fill_pkg;

    typedef enum logic [2:0] {
        FL_HDR,
        FL_DATA,
        FL_CSUM,
        FL_DONE,
        FL_ERR
    } fl_state_e;

    localparam int unsigned LANE_W   = 2;
    localparam int unsigned FILL_LAT = 1;

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; o_word is valid only while o_word_done.
module byte_assembler
    import fill_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [LANE_W-1:0] r_lane;
    logic [23:0]       r_part;

    // The top lane is never stored; the completed word is presented with the fourth byte.
    assign o_word      = {i_byte, r_part};
    assign o_word_done = i_accept && (r_lane == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
            r_part <= '0;
        end else if (i_clr) begin
            r_lane <= '0;
            r_part <= '0;
        end else if (i_accept) begin
            r_lane <= r_lane + LANE_W'(1);
            case (r_lane)
                2'd0:    r_part[7:0]   <= i_byte;
                2'd1:    r_part[15:8]  <= i_byte;
                2'd2:    r_part[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fill_loader.sv
// Program-image loader: header word count, data fills, optional trailer checksum.
// Optional checksum trailer is enabled by defining INSTR_FILL_CHECKSUM_EN.
module instr_fill_loader
    import fill_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned WCNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        ByteVal_FL0,
    input  logic [7:0]  ByteDat_FL0,
    output logic        ByteRdy_FL0,
    output logic [31:0] IntrAddr_FL0,
    output logic [31:0] IntrFill_FL0,
    output logic        FillVal_FL0,
    output logic        CoreReset_FL0,
    output logic        LoadDone_FL0,
    output logic        LoadErr_FL0
);

    fl_state_e         r_state, w_state_nxt;
    logic              r_live, r_core_rst, r_fill_val;
    logic [31:0]       r_addr, r_data;
    logic [WCNT_W-1:0] r_count, r_idx;
    logic              w_rdy, w_accept, w_word_done, w_last;
    logic [31:0]       w_word;
    logic [WCNT_W-1:0] w_hdr_count;

    // r_live keeps the handshake closed until the first clock after reset release.
    assign w_rdy       = r_live && !Start && (r_state inside {FL_HDR, FL_DATA, FL_CSUM});
    assign w_accept    = ByteVal_FL0 && w_rdy;
    assign w_hdr_count = w_word[WCNT_W-1:0];
    assign w_last      = (r_idx == r_count - WCNT_W'(1));

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (Start),
        .i_accept   (w_accept),
        .i_byte     (ByteDat_FL0),
        .o_word     (w_word),
        .o_word_done(w_word_done)
    );

`ifdef INSTR_FILL_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (Start) begin
            r_sum <= '0;
        end else if (w_word_done && (r_state == FL_DATA)) begin
            r_sum <= r_sum + w_word;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FL_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (Start) begin
            w_state_nxt = FL_HDR;
        end else if (w_word_done) begin
            unique case (r_state)
                FL_HDR: begin
                    if ((w_hdr_count == '0) || (32'(w_hdr_count) > MAX_WORDS)) begin
                        w_state_nxt = FL_ERR;
                    end else begin
                        w_state_nxt = FL_DATA;
                    end
                end
                FL_DATA: begin
                    if (w_last) begin
`ifdef INSTR_FILL_CHECKSUM_EN
                        w_state_nxt = FL_CSUM;
`else
                        w_state_nxt = FL_DONE;
`endif
                    end
                end
`ifdef INSTR_FILL_CHECKSUM_EN
                FL_CSUM: w_state_nxt = (w_word == r_sum) ? FL_DONE : FL_ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live     <= 1'b0;
            r_core_rst <= 1'b1;
            r_fill_val <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_data     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
        end else begin
            r_live     <= 1'b1;
            r_fill_val <= 1'b0;
            if (Start) begin
                r_core_rst <= 1'b1;
                r_count    <= '0;
                r_idx      <= '0;
            end else begin
                // One cycle behind FL_DONE so the last fill lands before the core runs.
                if (r_state == FL_DONE) begin
                    r_core_rst <= 1'b0;
                end
                if (w_word_done && (r_state == FL_HDR)) begin
                    r_count <= w_hdr_count;
                    r_idx   <= '0;
                end
                if (w_word_done && (r_state == FL_DATA)) begin
                    r_fill_val <= 1'b1;
                    r_addr     <= BASE_ADDR + (32'(r_idx) << 2);
                    r_data     <= w_word;
                    r_idx      <= r_idx + WCNT_W'(1);
                end
            end
        end
    end

    assign ByteRdy_FL0   = w_rdy;
    assign IntrAddr_FL0  = r_addr;
    assign IntrFill_FL0  = r_data;
    assign FillVal_FL0   = r_fill_val;
    assign CoreReset_FL0 = r_core_rst;
    assign LoadDone_FL0  = (r_state == FL_DONE);
    assign LoadErr_FL0   = (r_state == FL_ERR);

endmodule
